// File: rtl/hnf_sn_read_tracker_pkg.sv
// Shared CHI types and constants for the HN-F to SN ReadNoSnp tracker.
// Flit layouts are reduced to the fields this tracker touches.
package hnf_sn_read_tracker_pkg;

  localparam int NUM_ENTRIES = 4;
  localparam int RSP_CREDITS = 4;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ISSUE,
    ST_WAIT_RSP,
    ST_WAIT_PCRD,
    ST_REISSUE
  } entry_state_e;

  localparam logic [4:0] RSP_RETRYACK    = 5'h03;
  localparam logic [4:0] RSP_PCRDGRANT   = 5'h07;
  localparam logic [4:0] RSP_READRECEIPT = 5'h08;
  localparam logic [5:0] REQ_READNOSNP   = 6'h04;

  typedef struct packed {
    logic [6:0]  TgtID;
    logic [6:0]  SrcID;
    logic [7:0]  TxnID;
    logic [6:0]  ReturnNID;
    logic [5:0]  Opcode;
    logic [47:0] Addr;
    logic        AllowRetry;
    logic [3:0]  PCrdType;
  } reqflit_t;

  typedef struct packed {
    logic [6:0] TgtID;
    logic [6:0] SrcID;
    logic [7:0] TxnID;
    logic [4:0] Opcode;
    logic [3:0] PCrdType;
  } rspflit_t;

endpackage

// File: rtl/hnf_lcrd_counter.sv
// Saturating up/down link-credit counter.
// Simultaneous return and spend leave the count unchanged.
module hnf_lcrd_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hnf_sn_read_tracker.sv
// Tracks ReadNoSnp requests from SLC to SN with link credits,
// retry / protocol-credit handling and RXRSP credit return.
module hnf_sn_read_tracker
  import hnf_sn_read_tracker_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  reqflit_t read_no_snp,
  input  logic     read_no_snp_v,
  output logic     read_no_snp_ready,
  output reqflit_t txreq_flit,
  output logic     txreq_flitv,
  input  logic     txreq_lcrdv,
  input  rspflit_t rxrsp_flit,
  input  logic     rxrsp_flitv,
  output logic     rxrsp_lcrdv,
  output logic     busy,
  output logic     err_unexp_rsp
);

  typedef logic [IDX_W-1:0] idx_t;
  localparam logic [2:0] PG_MAX = 3'd4;

  entry_state_e st_q [NUM_ENTRIES];
  entry_state_e st_d [NUM_ENTRIES];
  reqflit_t     fl_q [NUM_ENTRIES];
  reqflit_t     fl_d [NUM_ENTRIES];
  logic [3:0]   pt_q [NUM_ENTRIES];
  logic [3:0]   pt_d [NUM_ENTRIES];

  logic [2:0] pg_q, pg_d;
  logic [2:0] ini_q, ini_d;
  logic [2:0] ret_q, ret_d;
  reqflit_t   tx_q, tx_d;
  logic       txv_q, lv_q, lv_d, err_q, err_d, en_q;

  logic alloc_ok, send_ok, pw_ok, gr_ok, any_busy;
  idx_t alloc_idx, send_idx, pw_idx, gr_idx, rsp_idx;
  logic do_alloc, do_send, do_cons;
  logic hit, is_rr, is_ra, is_pg;
  logic [3:0] cred_cnt;
  logic unused_rsp;

  hnf_lcrd_counter #(.W(4)) u_txreq_crd (
    .clock (clock),
    .reset (reset),
    .inc_i (txreq_lcrdv),
    .dec_i (do_send),
    .cnt_o (cred_cnt)
  );

  assign unused_rsp = ^{rxrsp_flit.TgtID, rxrsp_flit.SrcID};

  // Descending scans so the lowest index wins.
  always_comb begin
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    send_ok   = 1'b0;
    send_idx  = '0;
    pw_ok     = 1'b0;
    pw_idx    = '0;
    any_busy  = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (st_q[i] == ST_IDLE) begin
        alloc_ok  = 1'b1;
        alloc_idx = idx_t'(i);
      end else begin
        any_busy = 1'b1;
      end
      if (st_q[i] == ST_WAIT_ISSUE || st_q[i] == ST_REISSUE) begin
        send_ok  = 1'b1;
        send_idx = idx_t'(i);
      end
      if (st_q[i] == ST_WAIT_PCRD) begin
        pw_ok  = 1'b1;
        pw_idx = idx_t'(i);
      end
    end
  end

  assign read_no_snp_ready = en_q && alloc_ok;
  assign busy              = any_busy;
  assign do_alloc          = read_no_snp_v && read_no_snp_ready;
  assign do_send           = send_ok && (cred_cnt != 4'd0);
  assign do_cons           = pw_ok && (pg_q != 3'd0);

  assign rsp_idx = rxrsp_flit.TxnID[IDX_W-1:0];
  assign hit     = (rxrsp_flit.TxnID < 8'(NUM_ENTRIES))
                && (st_q[rsp_idx] == ST_WAIT_RSP);
  assign is_rr   = rxrsp_flitv && (rxrsp_flit.Opcode == RSP_READRECEIPT);
  assign is_ra   = rxrsp_flitv && (rxrsp_flit.Opcode == RSP_RETRYACK);
  assign is_pg   = rxrsp_flitv && (rxrsp_flit.Opcode == RSP_PCRDGRANT);
  assign err_d   = rxrsp_flitv && !is_pg && !((is_rr || is_ra) && hit);

  // A grant skips the entry already taking a banked grant this cycle.
  always_comb begin
    gr_ok  = 1'b0;
    gr_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (st_q[i] == ST_WAIT_PCRD && pt_q[i] == rxrsp_flit.PCrdType
          && !(do_cons && pw_idx == idx_t'(i))) begin
        gr_ok  = 1'b1;
        gr_idx = idx_t'(i);
      end
    end
  end

  always_comb begin
    st_d = st_q;
    fl_d = fl_q;
    pt_d = pt_q;
    pg_d = pg_q;
    if (do_alloc) begin
      st_d[alloc_idx]            = ST_WAIT_ISSUE;
      fl_d[alloc_idx]            = read_no_snp;
      fl_d[alloc_idx].TxnID      = 8'(alloc_idx);
      fl_d[alloc_idx].AllowRetry = 1'b1;
      fl_d[alloc_idx].PCrdType   = '0;
    end
    if (do_send)
      st_d[send_idx] = ST_WAIT_RSP;
    if (is_rr && hit)
      st_d[rsp_idx] = ST_IDLE;
    if (is_ra && hit) begin
      st_d[rsp_idx] = ST_WAIT_PCRD;
      pt_d[rsp_idx] = rxrsp_flit.PCrdType;
    end
    if (do_cons) begin
      st_d[pw_idx]            = ST_REISSUE;
      fl_d[pw_idx].AllowRetry = 1'b0;
      fl_d[pw_idx].PCrdType   = pt_q[pw_idx];
      pg_d                    = pg_q - 3'd1;
    end
    if (is_pg) begin
      if (gr_ok) begin
        st_d[gr_idx]            = ST_REISSUE;
        fl_d[gr_idx].AllowRetry = 1'b0;
        fl_d[gr_idx].PCrdType   = rxrsp_flit.PCrdType;
      end else if (pg_d != PG_MAX) begin
        pg_d = pg_d + 3'd1;
      end
    end
  end

  always_comb begin
    tx_d = tx_q;
    if (do_send) tx_d = fl_q[send_idx];
  end

  // Initial credit burst first; owed returns bank in ret_q meanwhile.
  always_comb begin
    ini_d = ini_q;
    ret_d = ret_q;
    lv_d  = 1'b0;
    if (ini_q != 3'(RSP_CREDITS)) begin
      lv_d  = 1'b1;
      ini_d = ini_q + 3'd1;
      if (rxrsp_flitv && ret_q != 3'd7) ret_d = ret_q + 3'd1;
    end else begin
      lv_d = rxrsp_flitv || (ret_q != 3'd0);
      if (!rxrsp_flitv && lv_d) ret_d = ret_q - 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        st_q[i] <= ST_IDLE;
        fl_q[i] <= '0;
        pt_q[i] <= '0;
      end
      pg_q  <= '0;
      ini_q <= '0;
      ret_q <= '0;
      tx_q  <= '0;
      txv_q <= 1'b0;
      lv_q  <= 1'b0;
      err_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      fl_q  <= fl_d;
      pt_q  <= pt_d;
      pg_q  <= pg_d;
      ini_q <= ini_d;
      ret_q <= ret_d;
      tx_q  <= tx_d;
      txv_q <= do_send;
      lv_q  <= lv_d;
      err_q <= err_d;
      en_q  <= 1'b1;
    end
  end

  assign txreq_flit    = tx_q;
  assign txreq_flitv   = txv_q;
  assign rxrsp_lcrdv   = lv_q;
  assign err_unexp_rsp = err_q;

endmodule

// File: tb/tb_hnf_sn_read_tracker.sv
// Self-checking bench: directed scenarios plus a randomized run
// against a transaction-level model of the tracker.
module tb_hnf_sn_read_tracker;
  import hnf_sn_read_tracker_pkg::*;

  logic     clock = 1'b0;
  logic     reset = 1'b1;
  reqflit_t read_no_snp;
  logic     read_no_snp_v;
  logic     read_no_snp_ready;
  reqflit_t txreq_flit;
  logic     txreq_flitv;
  logic     txreq_lcrdv;
  rspflit_t rxrsp_flit;
  logic     rxrsp_flitv;
  logic     rxrsp_lcrdv;
  logic     busy;
  logic     err_unexp_rsp;

  int checks = 0;
  int errors = 0;
  reqflit_t txq[$];
  int lcrdv_cnt = 0;
  int err_cnt = 0;

  hnf_sn_read_tracker dut (
    .clock             (clock),
    .reset             (reset),
    .read_no_snp       (read_no_snp),
    .read_no_snp_v     (read_no_snp_v),
    .read_no_snp_ready (read_no_snp_ready),
    .txreq_flit        (txreq_flit),
    .txreq_flitv       (txreq_flitv),
    .txreq_lcrdv       (txreq_lcrdv),
    .rxrsp_flit        (rxrsp_flit),
    .rxrsp_flitv       (rxrsp_flitv),
    .rxrsp_lcrdv       (rxrsp_lcrdv),
    .busy              (busy),
    .err_unexp_rsp     (err_unexp_rsp)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (txreq_flitv) txq.push_back(txreq_flit);
    if (rxrsp_lcrdv) lcrdv_cnt++;
    if (err_unexp_rsp) err_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  function automatic reqflit_t mk_flit(input logic [47:0] a);
    reqflit_t f;
    f = '0;
    f.Opcode = REQ_READNOSNP;
    f.Addr = a;
    f.SrcID = 7'h10;
    f.TgtID = 7'h30;
    f.ReturnNID = 7'h22;
    f.TxnID = 8'($urandom);
    f.AllowRetry = 1'($urandom);
    return f;
  endfunction

  function automatic logic [47:0] rnd_addr();
    return 48'({$urandom, $urandom});
  endfunction

  task automatic rd(input logic [47:0] a);
    int n = 0;
    while (!read_no_snp_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL rd_ready_timeout got ready=0 want 1");
    end
    read_no_snp = mk_flit(a);
    read_no_snp_v = 1'b1;
    step();
    read_no_snp_v = 1'b0;
  endtask

  task automatic rsp(input logic [4:0] op, input logic [7:0] id);
    rxrsp_flit = '0;
    rxrsp_flit.Opcode = op;
    rxrsp_flit.TxnID = id;
    rxrsp_flit.SrcID = 7'h30;
    rxrsp_flitv = 1'b1;
    step();
    rxrsp_flitv = 1'b0;
  endtask

  task automatic credit(input int n);
    txreq_lcrdv = 1'b1;
    wait_n(n);
    txreq_lcrdv = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    read_no_snp_v = 1'b0;
    txreq_lcrdv = 1'b0;
    rxrsp_flitv = 1'b0;
    wait_n(2);
    reset = 1'b1;
    wait_n(6);
    txq.delete();
    lcrdv_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic test_reset();
    logic [5:0] pat;
    read_no_snp = '0;
    read_no_snp_v = 1'b0;
    txreq_lcrdv = 1'b0;
    rxrsp_flit = '0;
    rxrsp_flitv = 1'b0;
    #2 reset = 1'b0;
    wait_n(3);
    checks++;
    if ({read_no_snp_ready, busy, txreq_flitv, rxrsp_lcrdv, err_unexp_rsp} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
        {read_no_snp_ready, busy, txreq_flitv, rxrsp_lcrdv, err_unexp_rsp});
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (read_no_snp_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got %b want 0", read_no_snp_ready);
    end
    step();
    checks++;
    if (read_no_snp_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_first_edge got %b want 1", read_no_snp_ready);
    end
    pat[0] = rxrsp_lcrdv;
    for (int i = 1; i < 6; i++) begin
      step();
      pat[i] = rxrsp_lcrdv;
    end
    checks++;
    if (pat !== 6'b001111) begin
      errors++;
      $display("FAIL init_lcrdv got %b want 001111", pat);
    end
  endtask

  task automatic test_credit_gating();
    logic [47:0] a[3];
    do_reset();
    for (int i = 0; i < 3; i++) a[i] = rnd_addr();
    credit(2);
    for (int i = 0; i < 3; i++) rd(a[i]);
    wait_n(6);
    checks++;
    if (txq.size() != 2) begin
      errors++;
      $display("FAIL gate_count got %0d want 2", txq.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (txq[i].TxnID !== 8'(i) || txq[i].Addr !== a[i] || txq[i].AllowRetry !== 1'b1
            || txq[i].ReturnNID !== 7'h22) begin
          errors++;
          $display("FAIL gate_flit%0d got id=%0d addr=%h ar=%b want id=%0d addr=%h ar=1",
            i, txq[i].TxnID, txq[i].Addr, txq[i].AllowRetry, i, a[i]);
        end
      end
    end
    credit(1);
    step();
    checks++;
    if (txreq_flitv !== 1'b1 || txreq_flit.TxnID !== 8'd2 || txreq_flit.Addr !== a[2]) begin
      errors++;
      $display("FAIL gate_third got v=%b id=%0d want v=1 id=2", txreq_flitv, txreq_flit.TxnID);
    end
  endtask

  task automatic test_full();
    logic [47:0] x;
    do_reset();
    credit(4);
    for (int i = 0; i < 4; i++) rd(rnd_addr());
    wait_n(4);
    checks++;
    if (read_no_snp_ready !== 1'b0 || txq.size() != 4) begin
      errors++;
      $display("FAIL full_ready got ready=%b sent=%0d want ready=0 sent=4",
        read_no_snp_ready, txq.size());
    end
    rsp(RSP_READRECEIPT, 8'd2);
    checks++;
    if (read_no_snp_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_free got ready=%b want 1", read_no_snp_ready);
    end
    x = rnd_addr();
    rd(x);
    checks++;
    if (read_no_snp_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_again got ready=%b want 0", read_no_snp_ready);
    end
    credit(1);
    wait_n(3);
    checks++;
    if (txq.size() != 5 || txq[txq.size()-1].TxnID !== 8'd2 || txq[txq.size()-1].Addr !== x) begin
      errors++;
      $display("FAIL full_realloc got sent=%0d want 5 with id=2", txq.size());
    end
  endtask

  task automatic test_retry();
    logic [47:0] a0, a1;
    do_reset();
    a0 = rnd_addr();
    a1 = rnd_addr();
    credit(3);
    rd(a0);
    rd(a1);
    wait_n(4);
    rsp(RSP_RETRYACK, 8'd1);
    wait_n(4);
    checks++;
    if (txq.size() != 2) begin
      errors++;
      $display("FAIL retry_hold got sent=%0d want 2", txq.size());
    end
    rsp(RSP_PCRDGRANT, 8'd0);
    wait_n(4);
    checks++;
    if (txq.size() != 3 || txq[2].TxnID !== 8'd1 || txq[2].AllowRetry !== 1'b0
        || txq[2].Addr !== a1 || txq[2].PCrdType !== 4'd0) begin
      errors++;
      $display("FAIL retry_resend got sent=%0d want 3 with id=1 ar=0 addr=%h", txq.size(), a1);
    end
    rsp(RSP_READRECEIPT, 8'd1);
    rsp(RSP_READRECEIPT, 8'd0);
    step();
    checks++;
    if (busy !== 1'b0 || err_cnt != 0) begin
      errors++;
      $display("FAIL retry_done got busy=%b errs=%0d want busy=0 errs=0", busy, err_cnt);
    end
  endtask

  task automatic test_early_grant();
    logic [47:0] a;
    do_reset();
    a = rnd_addr();
    credit(3);
    rd(a);
    wait_n(3);
    rsp(RSP_PCRDGRANT, 8'd0);
    step();
    rsp(RSP_RETRYACK, 8'd0);
    wait_n(5);
    checks++;
    if (txq.size() != 2 || txq[1].TxnID !== 8'd0 || txq[1].AllowRetry !== 1'b0 || txq[1].Addr !== a) begin
      errors++;
      $display("FAIL early_resend got sent=%0d want 2 with id=0 ar=0", txq.size());
    end
    rsp(RSP_RETRYACK, 8'd0);
    wait_n(5);
    checks++;
    if (txq.size() != 2) begin
      errors++;
      $display("FAIL early_pg_zero got sent=%0d want 2", txq.size());
    end
    rsp(RSP_PCRDGRANT, 8'd0);
    wait_n(4);
    rsp(RSP_READRECEIPT, 8'd0);
    step();
    checks++;
    if (txq.size() != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_done got sent=%0d busy=%b want 3 0", txq.size(), busy);
    end
  endtask

  task automatic test_unexpected();
    do_reset();
    rsp(RSP_READRECEIPT, 8'd3);
    checks++;
    if (err_unexp_rsp !== 1'b1 || rxrsp_lcrdv !== 1'b1) begin
      errors++;
      $display("FAIL unexp_pulse got err=%b lcrdv=%b want 1 1", err_unexp_rsp, rxrsp_lcrdv);
    end
    step();
    checks++;
    if (err_unexp_rsp !== 1'b0 || rxrsp_lcrdv !== 1'b0) begin
      errors++;
      $display("FAIL unexp_clear got err=%b lcrdv=%b want 0 0", err_unexp_rsp, rxrsp_lcrdv);
    end
    rsp(5'h01, 8'd0);
    checks++;
    if (err_unexp_rsp !== 1'b1) begin
      errors++;
      $display("FAIL unexp_opcode got err=%b want 1", err_unexp_rsp);
    end
    rsp(RSP_RETRYACK, 8'd9);
    checks++;
    if (err_unexp_rsp !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL unexp_txnid got err=%b busy=%b want 1 0", err_unexp_rsp, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    credit(1);
    for (int i = 0; i < 3; i++) rd(rnd_addr());
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b want 1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, read_no_snp_ready, txreq_flitv, rxrsp_lcrdv} !== 4'b0) begin
      errors++;
      $display("FAIL mid_in_reset got %b want 0000",
        {busy, read_no_snp_ready, txreq_flitv, rxrsp_lcrdv});
    end
    wait_n(2);
    txq.delete();
    lcrdv_cnt = 0;
    reset = 1'b1;
    txreq_lcrdv = 1'b1;
    wait_n(8);
    txreq_lcrdv = 1'b0;
    wait_n(2);
    checks++;
    if (lcrdv_cnt != RSP_CREDITS || txq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_release got lcrdv=%0d sent=%0d busy=%b want 4 0 0",
        lcrdv_cnt, txq.size(), busy);
    end
  endtask

  task automatic test_random();
    int st[NUM_ENTRIES];
    logic [47:0] ad[NUM_ENTRIES];
    int due[NUM_ENTRIES];
    int cred = 0;
    int acc = 0;
    int snt = 0;
    int cyc = 0;
    int lowf, r, t;
    logic v, lc, m_ready;
    logic [47:0] na;
    do_reset();
    for (int i = 0; i < NUM_ENTRIES; i++) st[i] = 0;
    while (cyc < 700) begin
      m_ready = 1'b0;
      lowf = -1;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
        if (st[i] == 0) begin
          m_ready = 1'b1;
          lowf = i;
        end
      checks++;
      if (read_no_snp_ready !== m_ready) begin
        errors++;
        $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, read_no_snp_ready, m_ready);
      end
      v = (cyc < 400) && m_ready && ($urandom_range(0, 2) != 0);
      na = rnd_addr();
      read_no_snp = mk_flit(na);
      read_no_snp_v = v;
      lc = (cyc >= 400) || ($urandom_range(0, 2) == 0);
      txreq_lcrdv = lc;
      r = -1;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
        if (st[i] == 2 && cyc >= due[i]) r = i;
      rxrsp_flit = '0;
      rxrsp_flit.Opcode = RSP_READRECEIPT;
      rxrsp_flit.TxnID = 8'(r < 0 ? 0 : r);
      rxrsp_flitv = (r >= 0);
      step();
      if (txreq_flitv) begin
        t = int'(txreq_flit.TxnID);
        checks++;
        if (t >= NUM_ENTRIES || cred <= 0 || st[t % NUM_ENTRIES] != 1
            || txreq_flit.Addr !== ad[t % NUM_ENTRIES] || txreq_flit.AllowRetry !== 1'b1) begin
          errors++;
          $display("FAIL rnd_send cyc=%0d got id=%0d addr=%h cred=%0d", cyc, t, txreq_flit.Addr, cred);
        end
        if (t < NUM_ENTRIES) begin
          st[t] = 2;
          due[t] = cyc + $urandom_range(1, 6);
        end
        cred--;
        snt++;
      end
      if (v && m_ready) begin
        st[lowf] = 1;
        ad[lowf] = na;
        acc++;
      end
      if (r >= 0) st[r] = 0;
      if (lc && cred < 15) cred++;
      cyc++;
      if (cyc > 400 && acc == snt && st[0] == 0 && st[1] == 0 && st[2] == 0 && st[3] == 0)
        break;
    end
    read_no_snp_v = 1'b0;
    txreq_lcrdv = 1'b0;
    rxrsp_flitv = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || acc != snt || acc == 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL rnd_drain got busy=%b acc=%0d sent=%0d errs=%0d want busy=0 acc=sent errs=0",
        busy, acc, snt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_credit_gating();
    test_full();
    test_retry();
    test_early_grant();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
